// File: rtl/viterbi_pkg.sv
// Constants and FSM state shared by the convolutional encoder and the Viterbi decoder.
// K=3, rate-1/2 code with generators 7 and 5 (octal).
package viterbi_pkg;

  localparam int K = 3;

  // Generator taps over {u, s1, s2}
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/conv_enc_step.sv
// One trellis step: maps input bit and shift-register state to coded pair and next state.
// Purely combinational so the decoder's branch-metric logic can reuse it.
module conv_enc_step
  import viterbi_pkg::*;
(
  input  logic i_u,
  input  logic i_s1,
  input  logic i_s2,
  output logic o_g0,
  output logic o_g1,
  output logic o_s1_next,
  output logic o_s2_next
);

  logic [K-1:0] w_reg;

  assign w_reg     = {i_u, i_s1, i_s2};
  assign o_g0      = ^(w_reg & G0);
  assign o_g1      = ^(w_reg & G1);
  assign o_s1_next = i_u;
  assign o_s2_next = i_s1;

endmodule

// File: rtl/conv_encoder.sv
// Frame-based rate-1/2 K=3 convolutional encoder: serial symbol stream plus parallel codeword.
// state   | meaning
// IDLE    | waiting for i_start; o_data holds the previous codeword
// ENC     | one message bit encoded per cycle, MSB first
// DONE    | codeword complete; o_done held until i_start drops
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int SIZE_DATA_IN  = 8,
  parameter int SIZE_DATA_OUT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [SIZE_DATA_IN-1:0]  i_data,
  output logic [SIZE_DATA_OUT-1:0] o_data,
  output logic [1:0]               o_sym,
  output logic                     o_sym_valid,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int CW = $clog2(SIZE_DATA_IN);
  localparam logic [CW-1:0] LAST = CW'(SIZE_DATA_IN - 1);

  enc_state_e              r_state;
  enc_state_e              w_state_next;
  logic [CW-1:0]           r_cnt;
  logic                    r_s1;
  logic                    r_s2;
  logic [SIZE_DATA_IN-1:0] r_data;
  logic [SIZE_DATA_OUT-1:0] r_code;
  logic [1:0]              r_sym;
  logic                    r_sym_valid;
  logic                    r_done;

  logic w_capture;
  logic w_enc;
  logic w_in_done;
  logic w_g0;
  logic w_g1;
  logic w_s1_next;
  logic w_s2_next;

  conv_enc_step u_step (
    .i_u       (r_data[SIZE_DATA_IN-1]),
    .i_s1      (r_s1),
    .i_s2      (r_s2),
    .o_g0      (w_g0),
    .o_g1      (w_g1),
    .o_s1_next (w_s1_next),
    .o_s2_next (w_s2_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // DONE waits one extra edge (r_done low) so o_done always rises before it can fall
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_next = ST_ENC;
      ST_ENC:  if (r_cnt == LAST) w_state_next = ST_DONE;
      ST_DONE: if (r_done && !i_start) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    w_enc     = 1'b0;
    w_in_done = 1'b0;
    case (r_state)
      ST_IDLE: w_capture = i_start;
      ST_ENC:  w_enc     = 1'b1;
      ST_DONE: w_in_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_data      <= '0;
      r_code      <= '0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
    end else if (w_capture) begin
      r_cnt       <= '0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_data      <= i_data;
      r_code      <= '0;
      r_sym_valid <= 1'b0;
    end else if (w_enc) begin
      r_s1        <= w_s1_next;
      r_s2        <= w_s2_next;
      r_data      <= r_data << 1;
      r_sym       <= {w_g0, w_g1};
      r_sym_valid <= 1'b1;
      if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
      for (int k = 0; k < SIZE_DATA_IN; k++) begin
        if (r_cnt == CW'(k)) r_code[SIZE_DATA_OUT-1-2*k -: 2] <= {w_g0, w_g1};
      end
    end else begin
      r_sym_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_done <= 1'b0;
    else if (w_in_done) r_done <= !r_done || i_start;
    else                r_done <= 1'b0;
  end

  assign o_busy      = w_enc;
  assign o_data      = r_code;
  assign o_sym       = r_sym;
  assign o_sym_valid = r_sym_valid;
  assign o_done      = r_done;

endmodule

// File: tb/tb_conv_encoder.sv
// Scoreboard bench for conv_encoder: expected symbols/codewords queued at stimulus,
// popped by a monitor when the DUT emits them.
module tb_conv_encoder;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_data = '0;
  logic [15:0] o_data;
  logic [1:0]  o_sym;
  logic        o_sym_valid;
  logic        o_busy;
  logic        o_done;

  conv_encoder #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(16)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_data      (i_data),
    .o_data      (o_data),
    .o_sym       (o_sym),
    .o_sym_valid (o_sym_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cap_cyc = 0;
  int sym_run = 0;
  logic prev_done = 1'b0;
  logic [1:0]  q_sym[$];
  logic [15:0] q_code[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc_model(input logic [7:0] d);
    logic [15:0] m;
    logic [7:0]  dd;
    logic        a, b, u;
    m = '0; dd = d; a = 1'b0; b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      u  = dd[7];
      dd = dd << 1;
      m  = {m[13:0], u ^ a ^ b, u ^ b};
      b  = a;
      a  = u;
    end
    return m;
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    #1;
    if (!i_rst_n) begin
      sym_run   = 0;
      prev_done = 1'b0;
    end else begin
      if (o_sym_valid) begin
        sym_run++;
        if (q_sym.size() == 0) chk("sym_extra", 32'(o_sym_valid), 32'd0);
        else chk("sym", 32'(o_sym), 32'(q_sym.pop_front()));
      end else if (sym_run != 0) begin
        chk("valid_len", 32'(sym_run), 32'd8);
        sym_run = 0;
      end
      if (o_done && !prev_done) begin
        if (q_code.size() == 0) chk("done_extra", 32'(o_done), 32'd0);
        else chk("code", 32'(o_data), 32'(q_code.pop_front()));
        chk("latency", 32'(cyc - cap_cyc), 32'd9);
      end
      prev_done = o_done;
    end
  end

  task automatic push_expect(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int k = 0; k < 8; k++) begin
      q_sym.push_back(c[15:14]);
      c = c << 2;
    end
    q_code.push_back(code);
  endtask

  // hold: cycles i_start stays high counted from capture; disturb: drop start / toggle data in ENC
  task automatic run_frame(input logic [7:0] d, input logic [15:0] exp_code,
                           input int hold, input bit disturb);
    int n;
    @(negedge i_clk);
    i_data  = d;
    i_start = 1'b1;
    push_expect(exp_code);
    @(posedge i_clk); #1;
    cap_cyc = cyc;
    chk("busy_e0", 32'(o_busy), 32'd1);
    chk("data_clr", 32'(o_data), 32'd0);
    n = 0;
    if (disturb) begin
      @(negedge i_clk);
      i_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        i_data = ~i_data;
        @(negedge i_clk);
      end
    end
    while (!o_done && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (!o_done) chk("done_timeout", 32'(o_done), 32'd1);
    if (!disturb) begin
      while ((cyc - cap_cyc) < hold) begin
        @(posedge i_clk); #1;
      end
      chk("done_hold", 32'(o_done), 32'd1);
      chk("busy_done", 32'(o_busy), 32'd0);
      chk("code_hold", 32'(o_data), 32'(exp_code));
      @(negedge i_clk);
      i_start = 1'b0;
      @(posedge i_clk); #1;
      chk("done_fall", 32'(o_done), 32'd0);
    end else begin
      @(posedge i_clk); #1;
      chk("done_fall_d", 32'(o_done), 32'd0);
    end
    chk("idle_code", 32'(o_data), 32'(exp_code));
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {11'd0, o_data, o_sym, o_sym_valid, o_busy, o_done}, 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    int n;
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_all_zero("idle_after_reset");

    run_frame(8'b11011010, 16'b1101010001010010, 10, 1'b0);
    run_frame(8'b10101010, 16'b1110001000100010, 10, 1'b0);
    run_frame(8'b00000001, 16'b0000000000000011, 10, 1'b0);
    run_frame(8'b00110011, 16'b0000110101111101, 9, 1'b0);
    run_frame(8'b10101010, 16'b1110001000100010, 9, 1'b0);
    run_frame(8'b11111111, enc_model(8'b11111111), 30, 1'b0);

    // Abort mid-frame with reset during symbol 4
    @(negedge i_clk);
    i_data  = 8'b11011010;
    i_start = 1'b1;
    push_expect(16'b1101010001010010);
    n = 0;
    do begin
      @(posedge i_clk); #2;
      n++;
    end while (sym_run != 4 && n < 20);
    chk("abort_reach", 32'(sym_run), 32'd4);
    i_rst_n = 1'b0;
    i_start = 1'b0;
    q_sym.delete();
    q_code.delete();
    #1;
    check_all_zero("abort_zero");
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("abort_idle");
    run_frame(8'b11011010, 16'b1101010001010010, 10, 1'b0);

    run_frame(8'b01100101, enc_model(8'b01100101), 10, 1'b1);

    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom_range(0, 255));
      run_frame(rd, enc_model(rd), 9 + i, 1'b0);
    end

    repeat (5) @(posedge i_clk);
    #1;
    chk("q_sym_left", 32'(q_sym.size()), 32'd0);
    chk("q_code_left", 32'(q_code.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter SIZE_DATA_IN, default 8, meaning the number of message bits per frame.
REQ-002 SHALL have parameter SIZE_DATA_OUT, default 16 (= 2*SIZE_DATA_IN), meaning the codeword width.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_start, input, 1 bit: frame request, level-sensitive.
REQ-006 SHALL have port i_data, input, SIZE_DATA_IN bits: message, MSB encoded first.
REQ-007 SHALL have port o_data, output, SIZE_DATA_OUT bits: parallel codeword; it feeds the decoder path i_data.
REQ-008 SHALL have port o_sym, output, 2 bits: current coded symbol {g0,g1}.
REQ-009 SHALL have port o_sym_valid, output, 1 bit: o_sym is valid this cycle.
REQ-010 SHALL have port o_busy, output, 1 bit: a frame is being encoded.
REQ-011 SHALL have port o_done, output, 1 bit: o_data is complete and stable.

Function
REQ-012 SHALL implement a rate-1/2, K=3 feed-forward code with generators g0=7 (octal, 111) and g1=5 (octal, 101) over {u, s1, s2}: g0 = u^s1^s2, g1 = u^s2.
REQ-013 SHALL clear the encoder state s1,s2 to 0 at each frame start; no tail bits SHALL be appended.
REQ-014 SHALL use the FSM IDLE -> ENC -> DONE -> IDLE.
REQ-015 IDLE: on an edge with i_start=1, SHALL latch i_data, clear o_data to 0, clear the bit counter and move to ENC; this is capture edge E0.
REQ-016 ENC: at edges E1..E8, SHALL encode bit k=0..7 (i_data bit 7-k) and shift u into s1 and s1 into s2.
REQ-017 ENC: at each of those edges, SHALL write symbol k into o_sym and into o_data[15-2k:14-2k], and set o_sym_valid=1.
REQ-018 o_sym_valid SHALL be high for exactly 8 consecutive cycles per frame (after E1 through E8) and low otherwise.
REQ-019 After E8, SHALL move to DONE; o_done SHALL rise at E9, 9 cycles after E0.
REQ-020 DONE: SHALL hold o_done=1 and o_data stable while i_start=1; it SHALL return to IDLE on the first edge with i_start=0, and o_done SHALL fall at that edge.
REQ-021 A held-high i_start SHALL NOT start a second frame.
REQ-022 o_busy SHALL be 1 exactly while in ENC.
REQ-023 i_start deasserted during ENC SHALL be ignored; the frame SHALL complete.
REQ-024 i_data changes after E0 SHALL be ignored.
REQ-025 In IDLE, o_data SHALL hold the last codeword until the next capture edge.
REQ-026 The bit counter SHALL be 3 bits wide; ENC SHALL exit when the counter reaches 7, with no wrap into a ninth symbol.

Reset
REQ-027 While i_rst_n=0, SHALL asynchronously force state=IDLE, counter=0, s1=s2=0, the latched data register=0, o_data=0, o_sym=0, o_sym_valid=0, o_busy=0 and o_done=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait in IDLE for i_start.

Structure
REQ-029 Package viterbi_pkg SHALL hold the constraint length K=3, the generator constants G0=3'b111 and G1=3'b101, and the FSM state enum; the downstream decoder SHALL share these.
REQ-030 One combinational sub-module, conv_enc_step, SHALL map (u, s1, s2) to (g0, g1, next state); it is reusable by the decoder's branch-metric logic.

Verification
REQ-031 Reset, then i_data=8'b11011010 with i_start held -> o_done rises 9 cycles after capture; o_data=16'b1101010001010010; o_sym sequence 11,01,01,00,01,01,00,10.
REQ-032 i_data=8'b10101010 -> o_data=16'b1110001000100010; i_data=8'b00000001 -> o_data=16'b0000000000000011.
REQ-033 i_data=8'b00110011 -> o_data=16'b0000110101111101; back-to-back frames with i_start dropped between them -> second frame independent of the first (state cleared).
REQ-034 i_start held high for 30 cycles -> exactly one frame; o_sym_valid high for exactly 8 cycles; o_done held until i_start=0.
REQ-035 i_rst_n pulsed low during symbol 4 -> all outputs 0 immediately; the next frame with 8'b11011010 still yields 16'b1101010001010010.
REQ-036 i_data toggled and i_start dropped during ENC -> codeword unchanged from the captured value; o_done still asserts.
